// File: rtl/z16_dmem_arbiter.sv
// Z16 data memory arbiter: round-robin between the CPU (port 0) and the loader/debug
// master (port 1), with a port-1 lock bounded by a watchdog. Optional stats: Z16_DMEM_ARB_STATS_EN.
module z16_dmem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_m0_req,
  input  logic              i_m0_wen,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  output logic              o_m0_gnt,
  output logic              o_m0_rvalid,
  output logic [DATA_W-1:0] o_m0_rdata,
  input  logic              i_m1_req,
  input  logic              i_m1_wen,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  input  logic              i_m1_lock,
  output logic              o_m1_gnt,
  output logic              o_m1_rvalid,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wen,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_locked,
  output logic              o_lock_timeout
`ifdef Z16_DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       o_conflict_cnt
`endif
);

  localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  typedef enum logic {S_IDLE, S_LOCKED} state_e;

  state_e            state_q, state_d;
  logic              r_last_q, r_last_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic              timeout_q, timeout_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_port_q, rd_port_d;
  logic              gnt0, gnt1;

  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    state_d    = state_q;
    r_last_d   = r_last_q;
    lock_cnt_d = lock_cnt_q;
    timeout_d  = 1'b0;

    // Grants are suppressed during reset so nothing reaches memory.
    if (!i_rst) begin
      if (state_q == S_LOCKED) begin
        gnt1 = i_m1_req;
      end else if (i_m0_req && i_m1_req) begin
        gnt0 = r_last_q;
        gnt1 = !r_last_q;
      end else begin
        gnt0 = i_m0_req;
        gnt1 = i_m1_req;
      end
    end

    if (gnt0) r_last_d = 1'b0;
    if (gnt1) r_last_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (gnt1 && i_m1_lock) begin
          state_d    = S_LOCKED;
          lock_cnt_d = '0;
        end
      end
      S_LOCKED: begin
        lock_cnt_d = lock_cnt_q + 1'b1;
        if (!i_m1_lock) begin
          state_d = S_IDLE;
        end else if (lock_cnt_q == CNT_LAST) begin
          // Watchdog release: hand the next tie to the CPU.
          state_d   = S_IDLE;
          r_last_d  = 1'b1;
          timeout_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rd_vld_d  = (gnt0 && !i_m0_wen) || (gnt1 && !i_m1_wen);
    rd_port_d = gnt1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      r_last_q   <= 1'b1;
      lock_cnt_q <= '0;
      timeout_q  <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_port_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_last_q   <= r_last_d;
      lock_cnt_q <= lock_cnt_d;
      timeout_q  <= timeout_d;
      rd_vld_q   <= rd_vld_d;
      rd_port_q  <= rd_port_d;
    end
  end

  always_comb begin
    o_m0_gnt    = gnt0;
    o_m1_gnt    = gnt1;
    o_mem_addr  = '0;
    o_mem_wen   = 1'b0;
    o_mem_wdata = '0;
    if (gnt0) begin
      o_mem_addr  = i_m0_addr;
      o_mem_wen   = i_m0_wen;
      o_mem_wdata = i_m0_wdata;
    end else if (gnt1) begin
      o_mem_addr  = i_m1_addr;
      o_mem_wen   = i_m1_wen;
      o_mem_wdata = i_m1_wdata;
    end
    // Masking with i_rst drops a response that would land in a reset cycle.
    o_m0_rvalid    = rd_vld_q && !rd_port_q && !i_rst;
    o_m1_rvalid    = rd_vld_q &&  rd_port_q && !i_rst;
    o_m0_rdata     = o_m0_rvalid ? i_mem_rdata : '0;
    o_m1_rdata     = o_m1_rvalid ? i_mem_rdata : '0;
    o_locked       = (state_q == S_LOCKED) && !i_rst;
    o_lock_timeout = timeout_q && !i_rst;
  end

`ifdef Z16_DMEM_ARB_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (i_m0_req && i_m1_req && conflict_cnt_q != 16'hFFFF)
      conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) conflict_cnt_q <= '0;
    else       conflict_cnt_q <= conflict_cnt_d;
  end

  assign o_conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_z16_dmem_arbiter.sv
// Bench for z16_dmem_arbiter: directed test-plan steps plus random traffic, checked
// against a cycle-level behavioural model of the arbitration rules.
module tb_z16_dmem_arbiter;
  localparam int LM = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_m0_req, i_m0_wen, i_m1_req, i_m1_wen, i_m1_lock;
  logic [15:0] i_m0_addr, i_m0_wdata, i_m1_addr, i_m1_wdata;
  logic        o_m0_gnt, o_m0_rvalid, o_m1_gnt, o_m1_rvalid;
  logic [15:0] o_m0_rdata, o_m1_rdata;
  logic [15:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
  logic        o_mem_wen, o_locked, o_lock_timeout;
`ifdef Z16_DMEM_ARB_STATS_EN
  logic [15:0] o_conflict_cnt;
`endif

  always #5 i_clk = ~i_clk;

  z16_dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .LOCK_MAX(LM)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_m0_req(i_m0_req), .i_m0_wen(i_m0_wen), .i_m0_addr(i_m0_addr), .i_m0_wdata(i_m0_wdata),
    .o_m0_gnt(o_m0_gnt), .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata),
    .i_m1_req(i_m1_req), .i_m1_wen(i_m1_wen), .i_m1_addr(i_m1_addr), .i_m1_wdata(i_m1_wdata),
    .i_m1_lock(i_m1_lock),
    .o_m1_gnt(o_m1_gnt), .o_m1_rvalid(o_m1_rvalid), .o_m1_rdata(o_m1_rdata),
    .o_mem_addr(o_mem_addr), .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .o_locked(o_locked), .o_lock_timeout(o_lock_timeout)
`ifdef Z16_DMEM_ARB_STATS_EN
    , .o_conflict_cnt(o_conflict_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // memory device contents and the model's own shadow copy
  logic [15:0] mem [int];
  logic [15:0] ref_mem [int];

  // reference model state
  bit          m_locked, m_last, m_tpulse, p_vld, p_port;
  int          m_age;
  logic [15:0] p_data;
  int          m_conf;
  logic [15:0] cap_rd0, cap_rd1;

  function automatic logic [15:0] mem_rd(logic [15:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : (a ^ 16'h5A5A);
  endfunction

  function automatic logic [15:0] ref_rd(logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : (a ^ 16'h5A5A);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_last = 1; m_tpulse = 0; m_age = 0; p_vld = 0; p_port = 0; p_data = 0; m_conf = 0;
  endtask

  // One clock cycle: drive inputs, check at negedge, then advance memory and model.
  task automatic step(input bit rst, input bit r0, input bit w0, input logic [15:0] a0,
                      input logic [15:0] d0, input bit r1, input bit w1, input logic [15:0] a1,
                      input logic [15:0] d1, input bit lk);
    bit e_g0, e_g1, e_wen;
    logic [15:0] e_addr, e_wd;
    bit cap_wen;
    logic [15:0] cap_addr, cap_wd;
    i_rst = rst; i_m0_req = r0; i_m0_wen = w0; i_m0_addr = a0; i_m0_wdata = d0;
    i_m1_req = r1; i_m1_wen = w1; i_m1_addr = a1; i_m1_wdata = d1; i_m1_lock = lk;
    @(negedge i_clk);
    e_g0 = 0; e_g1 = 0;
    if (!rst) begin
      if (m_locked) e_g1 = r1;
      else if (r0 && r1) begin e_g0 = m_last; e_g1 = !m_last; end
      else begin e_g0 = r0; e_g1 = r1; end
    end
    e_wen  = e_g0 ? w0 : e_g1 ? w1 : 1'b0;
    e_addr = e_g0 ? a0 : e_g1 ? a1 : 16'h0;
    e_wd   = e_g0 ? d0 : e_g1 ? d1 : 16'h0;
    chk("m0_gnt", o_m0_gnt, e_g0);
    chk("m1_gnt", o_m1_gnt, e_g1);
    chk("mem_wen", o_mem_wen, e_wen);
    chk("mem_addr", o_mem_addr, e_addr);
    chk("mem_wdata", o_mem_wdata, e_wd);
    chk("m0_rvalid", o_m0_rvalid, !rst && p_vld && !p_port);
    chk("m1_rvalid", o_m1_rvalid, !rst && p_vld && p_port);
    chk("m0_rdata", o_m0_rdata, (!rst && p_vld && !p_port) ? p_data : 16'h0);
    chk("m1_rdata", o_m1_rdata, (!rst && p_vld && p_port) ? p_data : 16'h0);
    chk("locked", o_locked, !rst && m_locked);
    chk("lock_timeout", o_lock_timeout, !rst && m_tpulse);
`ifdef Z16_DMEM_ARB_STATS_EN
    chk("conflict_cnt", o_conflict_cnt, m_conf);
`endif
    cap_rd0 = o_m0_rdata; cap_rd1 = o_m1_rdata;
    cap_wen = o_mem_wen; cap_addr = o_mem_addr; cap_wd = o_mem_wdata;
    @(posedge i_clk); #1;
    if (cap_wen) mem[int'(cap_addr)] = cap_wd;
    else i_mem_rdata = mem_rd(cap_addr);
    if (rst) model_reset();
    else begin
      if (r0 && r1 && m_conf < 16'hFFFF) m_conf++;
      p_vld  = (e_g0 || e_g1) && !e_wen;
      p_port = e_g1;
      p_data = ref_rd(e_addr);
      if (e_g0 || e_g1) begin
        if (e_wen) ref_mem[int'(e_addr)] = e_wd;
        m_last = e_g1;
      end
      m_tpulse = 0;
      if (!m_locked) begin
        if (e_g1 && lk) begin m_locked = 1; m_age = 0; end
      end else if (!lk) m_locked = 0;
      else if (m_age == LM - 1) begin m_locked = 0; m_last = 1; m_tpulse = 1; end
      else m_age++;
    end
  endtask

  task automatic idle(input bit rst);
    step(rst, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
  endtask

  initial begin
    i_mem_rdata = 16'h0;
    mem[16'h0010] = 16'hBEEF; ref_mem[16'h0010] = 16'hBEEF;
    model_reset();
    idle(1); idle(1);

    // single m0 read with a known memory word
    step(0, 1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    idle(0);
    chk("tp1_beef", cap_rd0, 16'hBEEF);

    // contention after reset alternates m0, m1, m0, m1
    idle(1);
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 16'(16'h100 + i), 16'h0, 1, 0, 16'(16'h200 + i), 16'h0, 0);
    idle(0);

    // lock held, then normal release: no timeout pulse
    idle(1);
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 16'h0030, 16'h0, 1, 1, 16'h0020, 16'h1234, 1);
    step(0, 1, 0, 16'h0030, 16'h0, 1, 1, 16'h0020, 16'h1234, 0);
    step(0, 1, 0, 16'h0030, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    idle(0);

    // lock never dropped: watchdog forces release
    idle(1);
    for (int i = 0; i < 9; i++)
      step(0, 1, 0, 16'h0040, 16'h0, 1, 0, 16'h0050, 16'h0, 1);

    // read response dropped by reset, then first tie goes to m0
    idle(1);
    step(0, 1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    idle(1);
    step(0, 1, 0, 16'h0060, 16'h0, 1, 0, 16'h0070, 16'h0, 0);
    idle(0);

    // conflict counting over five dual-request cycles, cleared by reset
    idle(1);
    for (int i = 0; i < 5; i++)
      step(0, 1, 1, 16'(i), 16'(i * 3), 1, 1, 16'(i + 8), 16'(i * 5), 0);
    idle(0);
    idle(1);
    idle(0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0,
           1'($urandom), 1'($urandom), 16'($urandom_range(0, 15)), 16'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom), 16'($urandom_range(0, 15)), 16'($urandom),
           $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/z16_dmem_arbiter.md
Name: z16_dmem_arbiter

Overview:
- Two-requester arbiter for the Z16 data memory port: sits between the memory and two masters.
- Port 0 is the CPU load/store path (address from the ALU result, write data from RS2). Port 1 is the loader/debug master.
- Round-robin on contention. Port 1 may lock the memory for atomic multi-access sequences; a watchdog bounds the lock.
- The memory reads with 1-cycle latency; the arbiter routes each read response back to the port that issued it.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- LOCK_MAX, 8, max consecutive LOCKED cycles before forced release (>=2)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset: synchronous, active-high
- i_m0_req  in  1  port0 access request; held until granted
- i_m0_wen  in  1  port0 write (1) / read (0)
- i_m0_addr  in  ADDR_W  port0 address
- i_m0_wdata  in  DATA_W  port0 write data
- o_m0_gnt  out  1  port0 access issued this cycle
- o_m0_rvalid  out  1  port0 read data valid
- o_m0_rdata  out  DATA_W  port0 read data
- i_m1_req, i_m1_wen, i_m1_addr, i_m1_wdata  in  1/1/ADDR_W/DATA_W  port1 request fields, same meaning as port0
- i_m1_lock  in  1  port1 requests/holds exclusive ownership
- o_m1_gnt, o_m1_rvalid, o_m1_rdata  out  1/1/DATA_W  port1 grant and response, same meaning as port0
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wen  out  1  memory write enable
- o_mem_wdata  out  DATA_W  memory write data
- i_mem_rdata  in  DATA_W  memory read data; valid the cycle after a read is issued
- o_locked  out  1  arbiter in LOCKED state
- o_lock_timeout  out  1  one-cycle pulse after a forced lock release

Behaviour:
- Grants are combinational from the current requests and state. At most one grant per cycle. A granted access issues in the same cycle.
- Memory mux:
  - o_mem_* carries the granted port's addr/wen/wdata.
  - With no grant: o_mem_wen=0, o_mem_addr=0, o_mem_wdata=0.
- State r_last (last granted port); reset value 1, so port0 wins the first tie.
- FSM IDLE:
  - Only one port requests: that port is granted.
  - Both request: the port != r_last is granted.
  - Each grant updates r_last.
  - Port1 granted with i_m1_lock=1: go to LOCKED next cycle and clear the lock counter.
- FSM LOCKED:
  - o_locked=1. o_m0_gnt=0 regardless of i_m0_req.
  - Port1 is granted whenever i_m1_req=1.
  - Counter increments every LOCKED cycle.
  - i_m1_lock=0: go to IDLE next cycle (normal release).
  - Counter==LOCK_MAX-1 while i_m1_lock=1: forced release. Go to IDLE next cycle, set r_last=1 (port0 wins the next tie), and register o_lock_timeout=1 for the first IDLE cycle.
  - Port1 may re-lock only via a new grant from IDLE.
- Read response:
  - A read granted in cycle N gives o_mX_rvalid=1 in cycle N+1 on the issuing port only, with o_mX_rdata=i_mem_rdata.
  - Otherwise rdata=0 and rvalid=0.
  - Writes produce no rvalid.
  - Back-to-back reads from alternating ports return in order, one per cycle, each to the correct port.
- Reset:
  - All grants=0, o_mem_wen=0, rvalid=0, o_locked=0, o_lock_timeout=0. State IDLE, counter 0, r_last=1.
  - A read issued in the cycle before i_rst rises has its response dropped (rvalid stays 0).
  - Reset while LOCKED releases immediately with no timeout pulse.
- Simultaneous events:
  - Port1 lock request while port0 wins the tie: no lock is taken. Port1 is granted next cycle under round-robin and locks then.

Optional Feature:
- Macro Z16_DMEM_ARB_STATS_EN.
- Defined: adds output o_conflict_cnt [15:0]. It increments (saturating at 16'hFFFF) each cycle i_m0_req && i_m1_req, including LOCKED cycles where port0 is blocked. Cleared by i_rst.
- Undefined: port absent, no counter logic.

Test Plan:
- Reset, then m0 read addr 16'h0010 (mem returns 16'hBEEF) -> o_m0_gnt=1 in cycle 0; o_m0_rvalid=1 and o_m0_rdata=16'hBEEF in cycle 1; o_m1_rvalid=0.
- Both request continuously for 4 cycles after reset -> grants m0,m1,m0,m1; rvalid follows on the correct port 1 cycle later.
- m1 write 16'h1234 @16'h0020 with lock=1 for 3 cycles, then lock=0, m0 requesting throughout -> o_m0_gnt=0 while o_locked=1; m0 granted the cycle after release; o_lock_timeout stays 0.
- LOCK_MAX=4, m1 holds lock and req indefinitely, m0 requests -> o_locked=1 for 4 cycles, then IDLE with o_lock_timeout=1 and o_m0_gnt=1 in the same cycle.
- m0 read granted, then i_rst asserted next cycle -> o_m0_rvalid=0; all outputs 0 during reset; first tie after reset goes to m0.
- With Z16_DMEM_ARB_STATS_EN: 5 cycles of dual requests -> o_conflict_cnt=5; reset clears it to 0.
